// File: rtl/arbiter_pkg.sv
// Shared definitions for the N-requester arbiter.
// Contents: priority mode encodings, FSM state enum, one-hot to index helper.
package arbiter_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic int unsigned onehot_to_idx(input logic [15:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (onehot[4'(i)]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   i_req  - request vector
//   i_base - index searched first; search runs upward and wraps N-1 -> 0
//   o_win  - one-hot winner (zero when no request)
//   o_any  - at least one request present
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_base,
    output logic [N-1:0]         o_win,
    output logic                 o_any
);

    localparam int unsigned IW = $clog2(N);

    // First set bit at or above i_base, wrapping around.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        o_win = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(i_base) + i) % N);
            if (!found && i_req[idx]) begin
                o_win[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/arbiter_rr.sv
// N-requester arbiter with fixed or round-robin priority, optional burst
// hold and a hold-timeout that forces release under contention.
// Ports:
//   i_clk       - clock, rising edge
//   i_rst       - asynchronous active-high reset
//   i_req       - request vector, bit k = requester k
//   o_gnt       - registered one-hot grant, zero when idle
//   o_gnt_valid - OR of o_gnt (registered)
//   o_gnt_id    - index of the granted requester; holds last value when idle
module arbiter_rr
    import arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MODE     = 1,
    parameter int unsigned HOLD_EN  = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    output logic [N_REQ-1:0]         o_gnt,
    output logic                     o_gnt_valid,
    output logic [$clog2(N_REQ)-1:0] o_gnt_id
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic [IW-1:0]     id_q, id_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     hold_cnt_q, hold_cnt_d;

    logic [IW-1:0]     base;
    logic [N_REQ-1:0]  win_full, win_others, new_win;
    logic              any_full, any_others, owner_req;
    logic              take_full, take_others;
    logic [IW-1:0]     new_idx;

    // Fixed priority always searches from index 0.
    assign base      = (MODE == MODE_FIXED) ? '0 : ptr_q;
    assign owner_req = |(i_req & gnt_q);

    rr_pick #(.N(N_REQ)) u_pick_full (
        .i_req  (i_req),
        .i_base (base),
        .o_win  (win_full),
        .o_any  (any_full)
    );

    // Same search with the current owner masked, used for forced release.
    rr_pick #(.N(N_REQ)) u_pick_others (
        .i_req  (i_req & ~gnt_q),
        .i_base (base),
        .o_win  (win_others),
        .o_any  (any_others)
    );

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        take_full   = 1'b0;
        take_others = 1'b0;
        new_win     = '0;
        new_idx     = '0;

        case (state_q)
            ST_IDLE: begin
                take_full = any_full;
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    if (any_full) begin
                        take_full = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                    end
                end else if (HOLD_EN == 0) begin
                    // Owner re-wins only by priority; pointer moves only on a change.
                    if (win_full != gnt_q) begin
                        take_full = 1'b1;
                    end
                    hold_cnt_d = '0;
                end else if (!any_others) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == CW'(MAX_HOLD - 1)) begin
                    take_others = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        if (take_full || take_others) begin
            new_win    = take_others ? win_others : win_full;
            new_idx    = IW'(onehot_to_idx(16'(new_win)));
            state_d    = ST_GRANT;
            gnt_d      = new_win;
            id_d       = new_idx;
            ptr_d      = (32'(new_idx) == N_REQ - 1) ? '0 : new_idx + IW'(1);
            hold_cnt_d = '0;
        end

        valid_d = |gnt_d;
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_gnt_valid = valid_q;
    assign o_gnt_id    = id_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr: four configurations driven with the
// same request vector, each compared every cycle against a reference model,
// plus directed scenarios with hand-derived expectations.
module tb_arbiter_rr;

    localparam int N  = 4;
    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt [NI];
    logic         vld [NI];
    logic [1:0]   gid [NI];

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance: owner (-1 = idle), last id,
    // rotation start, consecutive contended cycles already served.
    int m_owner [NI];
    int m_id    [NI];
    int m_ptr   [NI];
    int m_held  [NI];

    logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    arbiter_rr #(.N_REQ(4), .MODE(0), .HOLD_EN(0), .MAX_HOLD(8)) u_fix (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt[0]), .o_gnt_valid(vld[0]), .o_gnt_id(gid[0]));

    arbiter_rr #(.N_REQ(4), .MODE(1), .HOLD_EN(0), .MAX_HOLD(8)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt[1]), .o_gnt_valid(vld[1]), .o_gnt_id(gid[1]));

    arbiter_rr #(.N_REQ(4), .MODE(1), .HOLD_EN(1), .MAX_HOLD(8)) u_hold (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt[2]), .o_gnt_valid(vld[2]), .o_gnt_id(gid[2]));

    arbiter_rr #(.N_REQ(4), .MODE(0), .HOLD_EN(1), .MAX_HOLD(3)) u_fixh (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt[3]), .o_gnt_valid(vld[3]), .o_gnt_id(gid[3]));

    function automatic int cfg_mode(input int k);
        return (k == 1 || k == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_hold(input int k);
        return (k >= 2) ? 1 : 0;
    endfunction

    function automatic int cfg_max(input int k);
        return (k == 3) ? 3 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester found walking upward from base with wrap, skipping excl.
    function automatic int pick(input logic [N-1:0] r, input int base, input int excl);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (base + i) % N;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_owner[k] = -1;
            m_id[k]    = 0;
            m_ptr[k]   = 0;
            m_held[k]  = 0;
        end
    endtask

    task automatic model_grant(input int k, input int w);
        m_owner[k] = w;
        m_id[k]    = w;
        m_ptr[k]   = (w + 1) % N;
        m_held[k]  = 0;
    endtask

    task automatic model_step(input int k, input logic [N-1:0] r);
        int base;
        int w;
        int own;
        base = (cfg_mode(k) == 1) ? m_ptr[k] : 0;
        own  = m_owner[k];
        if (own < 0 || !r[own]) begin
            w = pick(r, base, -1);
            if (w >= 0) model_grant(k, w);
            else begin
                m_owner[k] = -1;
                m_held[k]  = 0;
            end
        end else if (cfg_hold(k) == 0) begin
            w = pick(r, base, -1);
            if (w != own) model_grant(k, w);
            m_held[k] = 0;
        end else if ((r & ~(4'b0001 << own)) == 4'b0000) begin
            m_held[k] = 0;
        end else if (m_held[k] + 1 >= cfg_max(k)) begin
            model_grant(k, pick(r, base, own));
        end else begin
            m_held[k] = m_held[k] + 1;
        end
    endtask

    task automatic check_model(input int k);
        int exp_g;
        exp_g = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
        check($sformatf("i%0d_gnt", k), 32'(gnt[k]), exp_g);
        check($sformatf("i%0d_vld", k), 32'(vld[k]), (m_owner[k] >= 0) ? 1 : 0);
        check($sformatf("i%0d_id", k),  32'(gid[k]), m_id[k]);
    endtask

    // Apply r, clock once, advance the model, compare one step after the edge.
    task automatic step(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k, r);
        #1;
        for (int k = 0; k < NI; k++) check_model(k);
    endtask

    // Outputs must clear while reset is high, before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_gnt%0d", k), 32'(gnt[k]), 0);
            check($sformatf("rst_vld%0d", k), 32'(vld[k]), 0);
            check($sformatf("rst_id%0d", k),  32'(gid[k]), 0);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] r;
        model_reset();
        #2;
        do_reset();

        // Fixed priority, no hold.
        repeat (4) begin
            step(4'b1010);
            check("fix_gnt", 32'(gnt[0]), 32'b0010);
            check("fix_id", 32'(gid[0]), 1);
        end
        step(4'b1000);
        check("fix_drop", 32'(gnt[0]), 32'b1000);

        // Round-robin rotation.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111);
            check("rr_seq", 32'(gnt[1]), 32'(rr_seq[i]));
        end

        // Hold with timeout.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b0001);
            check("hold_solo", 32'(gnt[2]), 32'b0001);
        end
        for (int i = 0; i < 7; i++) begin
            step(4'b0101);
            check("hold_keep", 32'(gnt[2]), 32'b0001);
        end
        step(4'b0101);
        check("hold_rel", 32'(gnt[2]), 32'b0100);
        check("hold_rel_id", 32'(gid[2]), 2);

        // Back-to-back handoff, then idle and regrant.
        do_reset();
        step(4'b0010);
        check("ho_first", 32'(gnt[1]), 32'b0010);
        check("ho_vld0", 32'(vld[1]), 1);
        step(4'b1000);
        check("ho_next", 32'(gnt[1]), 32'b1000);
        check("ho_vld1", 32'(vld[1]), 1);
        step(4'b0000);
        check("idle_gnt", 32'(gnt[1]), 0);
        check("idle_vld", 32'(vld[1]), 0);
        check("idle_id", 32'(gid[1]), 3);
        step(4'b0100);
        check("regrant", 32'(gnt[1]), 32'b0100);
        check("regrant_id", 32'(gid[1]), 2);

        // Reset while granting.
        step(4'b0110);
        step(4'b0110);
        check("pre_rst_vld", 32'(vld[1]), 1);
        do_reset();

        // Randomized traffic; sticky requests exercise holding and timeouts.
        r = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, N - 1)] = ~r[$urandom_range(0, N - 1)];
            if ($urandom_range(0, 799) == 0) do_reset();
            step(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Parametrised N-requester arbiter; next generation of the two-requester fixed-priority arbiter.
- Adds selectable fixed or round-robin priority, grant hold (burst ownership) and a hold-timeout counter that forces release under contention.
- Sits between shared-resource masters and the resource mux; the grant is registered, one-hot, and accompanied by an encoded owner ID.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- HOLD_EN, 1, 1 = owner keeps the grant while its request stays high; 0 = re-arbitrate every cycle.
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner while another request is pending (>=1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  N_REQ  request vector, bit k = requester k.
- o_gnt  out  N_REQ  registered one-hot grant; all zero when idle.
- o_gnt_valid  out  1  OR of o_gnt.
- o_gnt_id  out  $clog2(N_REQ)  index of the granted requester; holds its last value while idle.

Behaviour:
- Reset (async assert, sync-to-clock deassert by the source):
  - o_gnt=0, o_gnt_valid=0, o_gnt_id=0.
  - RR pointer=0, hold_cnt=0, FSM=IDLE.
- Latency: i_req sampled at edge t -> o_gnt valid after edge t. One cycle, no combinational path from i_req to outputs.
- Winner selection (combinational, from i_req masked as below):
  - MODE=0: lowest set index.
  - MODE=1: first set bit searching upward from pointer, wrapping N_REQ-1 -> 0.
- FSM IDLE:
  - any i_req -> GRANT; o_gnt = winner; hold_cnt=0; pointer = (winner+1) mod N_REQ.
  - No request -> stay IDLE, outputs zero.
- FSM GRANT, owner = o_gnt_id:
  - Owner request low: re-arbitrate over i_req.
    - Any request -> new grant at the next edge, with no idle bubble.
    - No request -> IDLE, o_gnt=0.
  - HOLD_EN=0: re-arbitrate every cycle over the full i_req. Owner may win again only by priority, or in RR only when it is the sole requester.
  - HOLD_EN=1, owner request high:
    - Keep the grant; hold_cnt increments while another request is pending. hold_cnt resets to 0 when the owner is the sole requester.
    - When hold_cnt==MAX_HOLD-1 and another request is pending, the next edge grants the winner over i_req with the owner bit masked; hold_cnt=0.
    - Forced release applies in both modes. In MODE=0 the next-lowest pending index wins.
- Pointer updates only on a new grant (owner change or IDLE->GRANT); never updates while holding.
- o_gnt is always one-hot or zero; o_gnt_id always matches o_gnt when valid.
- Simultaneous events:
  - Owner drop and new requests at the same edge: the new requests compete normally.
  - Forced release when every other request drops at that same edge: owner keeps the grant.
- Reset mid-grant: outputs clear asynchronously. The first grant after reset uses pointer=0.
- N_REQ=2, MODE=0, HOLD_EN=0 reproduces the legacy two-requester arbiter, one cycle later-registered.

Decomposition:
- Package arbiter_pkg:
  - MODE_FIXED=0, MODE_RR=1.
  - FSM state enum {ST_IDLE, ST_GRANT}.
  - Function onehot_to_idx.
- Sub-module rr_pick: combinational N-bit rotating priority picker.
  - Inputs: request vector, base index.
  - Outputs: one-hot winner, any-flag.
  - MODE=0 drives base=0.

Test Plan:
- Reset: assert i_rst mid-grant with i_req=4'b0110 -> o_gnt=0, o_gnt_valid=0, o_gnt_id=0 immediately, without waiting for a clock edge.
- Fixed priority (MODE=0, HOLD_EN=0): i_req=4'b1010 held -> o_gnt=4'b0010 every cycle. Drop bit 1 -> o_gnt=4'b1000 one edge later.
- Round-robin (MODE=1, HOLD_EN=0): i_req=4'b1111 held -> o_gnt sequence 0001, 0010, 0100, 1000, 0001.
- Hold (MODE=1, HOLD_EN=1, MAX_HOLD=8): i_req=4'b0001 for 20 cycles -> grant 0 for all 20 cycles. Then i_req=4'b0101 -> grant 0 for 8 more cycles, then o_gnt=4'b0100, o_gnt_id=2.
- Back-to-back handoff: owner 1, i_req 4'b0010 -> 4'b1000 at edge t -> o_gnt=4'b1000 after edge t+1, o_gnt_valid never low.
- Idle: all requests drop -> o_gnt=0, o_gnt_valid=0, o_gnt_id retains the last index. Next i_req=4'b0100 -> grant after one edge.
